req_ack_rr_arbiter: RTL and testbench

Shares one downstream responder among N_REQ requesters using round-robin arbitration. The responder uses a single-cycle req/ack handshake: req_o is high for exactly one cycle, and ack_i is expected the following cycle or later. A watchdog aborts any transaction whose ack does not arrive within TIMEOUT cycles. The block sits between requester agents and the shared req/ack resource.

---
 rtl/req_ack_rr_arbiter_pkg.sv | 14 +
 rtl/req_ack_rr_arbiter_if.sv | 34 +++
 rtl/req_ack_rr_arbiter_pick.sv | 53 +++++
 rtl/req_ack_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_req_ack_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/req_ack_rr_arbiter_pkg.sv
// req_ack_pkg: shared definitions for the round-robin req/ack arbiter.
// Holds the controller state encoding used by the arbiter top module.
package req_ack_pkg;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

endpackage

// File: rtl/req_ack_rr_arbiter_if.sv
// req_ack_rr_arbiter_if: bundles the requester-side and responder-side
// handshake signals of the arbiter.
//   req_i      requester request levels     (N_REQ)
//   ack_o      one-hot completion pulse     (N_REQ)
//   err_o      one-hot timeout pulse        (N_REQ)
//   req_o      1-cycle request to responder (1)
//   ack_i      responder acknowledge        (1)
//   grant_id_o index of current/last owner  (ID_W)
//   busy_o     arbiter not idle             (1)
// slave  = arbiter view, master = environment (requesters + responder) view.
interface req_ack_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] ack_o;
  logic [N_REQ-1:0] err_o;
  logic             req_o;
  logic             ack_i;
  logic [ID_W-1:0]  grant_id_o;
  logic             busy_o;

  modport slave (
    input  req_i, ack_i,
    output ack_o, err_o, req_o, grant_id_o, busy_o
  );

  modport master (
    output req_i, ack_i,
    input  ack_o, err_o, req_o, grant_id_o, busy_o
  );

endinterface

// File: rtl/req_ack_rr_arbiter_pick.sv
// req_ack_rr_pick: combinational round-robin winner selection.
//   req         request vector (N_REQ)
//   last_winner index granted most recently (ID_W)
//   winner      first requester above last_winner, wrapping (ID_W)
//   valid       at least one request present
// The request vector is duplicated and shifted so that the bit just above
// last_winner lands at position 0; the lowest set bit of that window is
// the winner, expressed as an offset from the start position.
module req_ack_rr_pick
  import req_ack_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_winner,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl_s;
  logic [ID_W:0]      start_s;
  logic [N_REQ-1:0]   rot_s;
  logic [ID_W:0]      offs_s;
  logic [ID_W:0]      sum_s;

  // Rotate requests to start after last_winner, then priority-encode
  always_comb begin
    dbl_s   = {req, req};
    start_s = {1'b0, last_winner} + (ID_W+1)'(1);
    rot_s   = N_REQ'(dbl_s >> start_s);
    offs_s  = '0;
    // Scan downward so the lowest set bit is the last one written
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        offs_s = (ID_W+1)'(i);
      end else begin
        offs_s = offs_s;
      end
    end
    // start + offset is at most 2*N_REQ-1, so one subtraction wraps it
    sum_s = start_s + offs_s;
    if (sum_s >= N_EXT) begin
      winner = ID_W'(sum_s - N_EXT);
    end else begin
      winner = ID_W'(sum_s);
    end
    valid = |req;
  end

endmodule

// File: rtl/req_ack_rr_arbiter.sv
// req_ack_rr_arbiter: shares one req/ack responder among N_REQ requesters
// with round-robin arbitration and a WAIT-state watchdog.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    req_ack_rr_arbiter_if.slave (req_i, ack_o, err_o, req_o, ack_i,
//          grant_id_o, busy_o)
// All outputs are registered; each output register is loaded from the value
// it must carry while the FSM sits in its next state.
module req_ack_rr_arbiter
  import req_ack_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  req_ack_rr_arbiter_if.slave  bus
);

  localparam int              ID_W     = $clog2(N_REQ);
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [ID_W-1:0]  last_r, last_s;
  logic [ID_W-1:0]  grant_r, grant_s;
  logic [N_REQ-1:0] ack_r, ack_s;
  logic [N_REQ-1:0] err_r, err_s;
  logic             req_r, req_s;
  logic             busy_r, busy_s;
  logic [ID_W-1:0]  pick_id_s;
  logic             pick_vld_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  req_ack_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req         (bus.req_i),
    .last_winner (last_r),
    .winner      (pick_id_s),
    .valid       (pick_vld_s)
  );

  // Next-state, watchdog counter, ownership and next output values
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    grant_s = grant_r;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          grant_s = pick_id_s;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = '0;
        state_s = WAIT;
      end
      WAIT: begin
        // ack has priority over a coincident timeout
        if (bus.ack_i) begin
          state_s = DONE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = FAULT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        last_s  = grant_r;
        state_s = IDLE;
      end
      FAULT: begin
        last_s  = grant_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    req_s  = (state_s == ISSUE);
    busy_s = (state_s != IDLE);
    if (state_s == DONE) begin
      ack_s = onehot(grant_s);
    end else begin
      ack_s = '0;
    end
    if (state_s == FAULT) begin
      err_s = onehot(grant_s);
    end else begin
      err_s = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      last_r  <= LAST_RST;
      grant_r <= '0;
      req_r   <= 1'b0;
      ack_r   <= '0;
      err_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      grant_r <= grant_s;
      req_r   <= req_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.req_o      = req_r;
  assign bus.ack_o      = ack_r;
  assign bus.err_o      = err_r;
  assign bus.grant_id_o = grant_r;
  assign bus.busy_o     = busy_r;

endmodule

// File: tb/tb_req_ack_rr_arbiter.sv
// tb_req_ack_rr_arbiter: scenario tasks driving requester wishes and a
// responder model; expected completions (owner, ack/err, latency from
// req_o) are queued when stimulus is issued and checked by a monitor.
module tb_req_ack_rr_arbiter;

  typedef struct {
    int id;
    bit err;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   done_cnt = 0;
  int   want[4];
  int   resp_lat = 1;
  bit   spur_idle = 1'b0;
  bit   spur_issue = 1'b0;

  req_ack_rr_arbiter_if #(.N_REQ(4)) bus ();

  req_ack_rr_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requesters: raise when wanted, drop on own ack/err, pause 2 cycles
  initial begin
    logic [3:0] r;
    int gap[4];
    r = 4'b0000;
    for (int i = 0; i < 4; i++) gap[i] = 0;
    bus.req_i = 4'b0000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.ack_o[i] || bus.err_o[i]) begin
          r[i] = 1'b0;
          gap[i] = 2;
        end else if (!r[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if (want[i] > 0) begin
            r[i] = 1'b1;
            want[i]--;
          end
        end
      end
      bus.req_i = r;
    end
  end

  // Responder: ack resp_lat cycles after req_o (0 = never), plus spurious acks
  initial begin
    bit a;
    bit pend;
    int cd;
    pend = 1'b0;
    cd = 0;
    bus.ack_i = 1'b0;
    forever begin
      @(negedge clk);
      a = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (pend) begin
        if (cd == 1) begin
          a = 1'b1;
          pend = 1'b0;
        end else cd--;
      end
      if (bus.req_o && resp_lat > 0) begin
        pend = 1'b1;
        cd = resp_lat;
      end
      if (spur_idle && !bus.busy_o) a = 1'b1;
      if (spur_issue && bus.req_o) a = 1'b1;
      bus.ack_i = a;
    end
  end

  // Monitor: every ack/err pulse is popped against the scoreboard
  initial begin
    int cyc;
    int req_cyc;
    int reqcnt;
    exp_t e;
    logic [3:0] ea, ee;
    logic [1:0] eid;
    cyc = 0;
    req_cyc = 0;
    reqcnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        reqcnt = 0;
      end else begin
        if (bus.req_o) begin
          reqcnt++;
          req_cyc = cyc;
        end
        if (bus.ack_o != 4'b0000 || bus.err_o != 4'b0000) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_completion ack_o=%b err_o=%b grant=%0d", bus.ack_o, bus.err_o, bus.grant_id_o);
          end else begin
            e = sb_q.pop_front();
            eid = e.id[1:0];
            ea = e.err ? 4'b0000 : (4'b0001 << e.id);
            ee = e.err ? (4'b0001 << e.id) : 4'b0000;
            if (bus.ack_o !== ea || bus.err_o !== ee || bus.grant_id_o !== eid ||
                reqcnt != 1 || (cyc - req_cyc) != e.lat) begin
              errors++;
              $display("FAIL completion got ack=%b err=%b grant=%0d req_o_pulses=%0d lat=%0d want ack=%b err=%b grant=%0d req_o_pulses=1 lat=%0d",
                       bus.ack_o, bus.err_o, bus.grant_id_o, reqcnt, cyc - req_cyc, ea, ee, eid, e.lat);
            end
          end
          reqcnt = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic push_exp(input int id, input bit err, input int lat);
    exp_t e;
    e.id = id;
    e.err = err;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_cnt = 0;
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (done_cnt < tgt && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.ack_o, bus.err_o, bus.req_o, bus.busy_o, bus.grant_id_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values ack=%b err=%b req_o=%b busy=%b grant=%0d want all zero",
               bus.ack_o, bus.err_o, bus.req_o, bus.busy_o, bus.grant_id_o);
    end
  endtask

  task automatic test_single();
    int busy_n;
    do_reset();
    resp_lat = 1;
    busy_n = 0;
    push_exp(0, 1'b0, 2);
    want[0] = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy_o) busy_n++;
    end
    checks++;
    if (busy_n != 3) begin
      errors++;
      $display("FAIL single_busy_cycles got %0d want 3", busy_n);
    end
    checks++;
    if (done_cnt !== 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_done got %0d want 1 (left %0d)", done_cnt, sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    resp_lat = 1;
    push_exp(0, 1'b0, 2);
    push_exp(1, 1'b0, 2);
    push_exp(2, 1'b0, 2);
    push_exp(3, 1'b0, 2);
    push_exp(0, 1'b0, 2);
    push_exp(1, 1'b0, 2);
    want[0] = 2; want[1] = 2; want[2] = 1; want[3] = 1;
    wait_done(6);
    checks++;
    if (done_cnt !== 6 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rr_done got %0d want 6 (left %0d)", done_cnt, sb_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    resp_lat = 0;
    push_exp(2, 1'b1, 9);
    want[2] = 1;
    wait_done(1);
    checks++;
    if (done_cnt !== 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_done got %0d want 1 (left %0d)", done_cnt, sb_q.size());
    end
    resp_lat = 1;
    push_exp(3, 1'b0, 2);
    push_exp(0, 1'b0, 2);
    want[0] = 1; want[3] = 1;
    wait_done(3);
    checks++;
    if (done_cnt !== 3 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL after_timeout_done got %0d want 3 (left %0d)", done_cnt, sb_q.size());
    end
  endtask

  task automatic test_ack_at_boundary();
    do_reset();
    resp_lat = 8;
    push_exp(1, 1'b0, 9);
    want[1] = 1;
    wait_done(1);
    checks++;
    if (done_cnt !== 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL boundary_done got %0d want 1 (left %0d)", done_cnt, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    resp_lat = 0;
    want[2] = 1; want[3] = 1;
    n = 0;
    while (!bus.req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.req_o) begin
      errors++;
      $display("FAIL reset_mid_issue got req_o=%b want 1", bus.req_o);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ack_o, bus.err_o, bus.req_o, bus.busy_o, bus.grant_id_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_async ack=%b err=%b req_o=%b busy=%b grant=%0d want all zero",
               bus.ack_o, bus.err_o, bus.req_o, bus.busy_o, bus.grant_id_o);
    end
    resp_lat = 1;
    push_exp(2, 1'b0, 2);
    push_exp(3, 1'b0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    wait_done(2);
    checks++;
    if (done_cnt !== 2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_done got %0d want 2 (left %0d)", done_cnt, sb_q.size());
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    resp_lat = 3;
    spur_idle = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.ack_o !== 4'b0000) begin
        errors++;
        $display("FAIL idle_spurious busy=%b ack_o=%b want 0 0000", bus.busy_o, bus.ack_o);
      end
    end
    spur_idle = 1'b0;
    @(negedge clk);
    spur_issue = 1'b1;
    push_exp(1, 1'b0, 4);
    want[1] = 1;
    wait_done(1);
    spur_issue = 1'b0;
    checks++;
    if (done_cnt !== 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL issue_spurious_done got %0d want 1 (left %0d)", done_cnt, sb_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) want[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ack_at_boundary();
    test_reset_mid();
    test_spurious_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
